// File: rtl/face_result_buffer.sv
// Rescales detect_face detections to full-image coordinates and queues them,
// with one end-of-frame entry per frame, on a first-word-fall-through stream.
module face_result_buffer #(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned WINDOW_SIZE = 24,
  parameter int unsigned NUM_LEVELS  = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0][31:0] face_coords,
  input  logic             face_coords_ready,
  input  logic [3:0]       pyramid_number,
  input  logic             vj_pipeline_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_row,
  output logic [15:0]      out_col,
  output logic [15:0]      out_size,
  output logic             out_is_face,
  output logic             out_last,
  output logic [7:0]       face_count,
  output logic [7:0]       drop_count
);

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam logic [15:0] WIN = 16'(WINDOW_SIZE);

  function automatic logic [15:0] scale_q88(input logic [3:0] lvl);
    case (lvl)
      4'd0:    scale_q88 = 16'd256;
      4'd1:    scale_q88 = 16'd320;
      4'd2:    scale_q88 = 16'd400;
      4'd3:    scale_q88 = 16'd500;
      4'd4:    scale_q88 = 16'd625;
      4'd5:    scale_q88 = 16'd781;
      4'd6:    scale_q88 = 16'd977;
      4'd7:    scale_q88 = 16'd1221;
      4'd8:    scale_q88 = 16'd1526;
      4'd9:    scale_q88 = 16'd1907;
      default: scale_q88 = 16'd0;
    endcase
  endfunction

  // Truncating Q8.8 multiply, saturating anything that overflows 16 bits.
  function automatic logic [15:0] rescale(input logic [15:0] v, input logic [15:0] s);
    logic [31:0] p;
    p = {16'd0, v} * {16'd0, s};
    rescale = (|p[31:24]) ? 16'hFFFF : p[23:8];
  endfunction

  logic        w_unused_hi;
  assign w_unused_hi = ^{face_coords[0][31:16], face_coords[1][31:16]};

  // Stage 1: capture
  logic [15:0] r_s1_row, r_s1_col;
  logic [3:0]  r_s1_lvl;
  logic        r_s1_face, r_s1_done;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_s1_row  <= '0;
      r_s1_col  <= '0;
      r_s1_lvl  <= '0;
      r_s1_face <= 1'b0;
      r_s1_done <= 1'b0;
    end else begin
      r_s1_row  <= face_coords[0][15:0];
      r_s1_col  <= face_coords[1][15:0];
      r_s1_lvl  <= pyramid_number;
      r_s1_face <= face_coords_ready;
      r_s1_done <= vj_pipeline_done;
    end
  end

  // Stage 2: rescale and level check
  logic [15:0] w_scale;
  logic        w_lvl_ok;
  logic [15:0] r_s2_row, r_s2_col, r_s2_size;
  logic        r_s2_face, r_s2_bad, r_s2_done;

  assign w_scale  = scale_q88(r_s1_lvl);
  assign w_lvl_ok = 32'(r_s1_lvl) < NUM_LEVELS;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_s2_row  <= '0;
      r_s2_col  <= '0;
      r_s2_size <= '0;
      r_s2_face <= 1'b0;
      r_s2_bad  <= 1'b0;
      r_s2_done <= 1'b0;
    end else begin
      r_s2_row  <= rescale(r_s1_row, w_scale);
      r_s2_col  <= rescale(r_s1_col, w_scale);
      r_s2_size <= rescale(WIN, w_scale);
      r_s2_face <= r_s1_face && w_lvl_ok;
      r_s2_bad  <= r_s1_face && !w_lvl_ok;
      r_s2_done <= r_s1_done;
    end
  end

  // Result FIFO: entry = {row, col, size, is_face, last}
  logic [49:0] r_mem [FIFO_DEPTH];
  logic [AW:0] r_wptr, r_rptr;
  logic [AW:0] w_count;
  logic [31:0] w_free;
  logic [49:0] w_head, w_wdata;
  logic        w_pop, w_pop_last, w_face_ok, w_wr, w_drop;

  assign w_count    = r_wptr - r_rptr;
  assign out_valid  = (w_count != '0);
  assign w_pop      = out_valid && out_ready;
  assign w_head     = r_mem[r_rptr[AW-1:0]];
  assign w_pop_last = w_pop && w_head[0];

  // One slot is always held back for the end-of-frame entry.
  assign w_free    = FIFO_DEPTH - 32'(w_count) + 32'(w_pop);
  assign w_face_ok = r_s2_face && (w_free >= 32'd2);
  assign w_wr      = w_face_ok || (r_s2_done && (w_free != '0));
  assign w_drop    = r_s2_bad || (r_s2_face && !w_face_ok);
  assign w_wdata   = w_face_ok ? {r_s2_row, r_s2_col, r_s2_size, 1'b1, r_s2_done}
                               : {48'd0, 1'b0, 1'b1};

  always_ff @(posedge clock) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= w_wdata;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
    end
  end

  // Popping the terminator starts a new frame; a same-cycle event counts toward it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      face_count <= '0;
      drop_count <= '0;
    end else if (w_pop_last) begin
      face_count <= {7'd0, w_face_ok};
      drop_count <= {7'd0, w_drop};
    end else begin
      if (w_face_ok && face_count != 8'hFF) face_count <= face_count + 8'd1;
      if (w_drop && drop_count != 8'hFF)    drop_count <= drop_count + 8'd1;
    end
  end

  always_comb begin
    out_row     = '0;
    out_col     = '0;
    out_size    = '0;
    out_is_face = 1'b0;
    out_last    = 1'b0;
    if (out_valid) begin
      out_row     = w_head[49:34];
      out_col     = w_head[33:18];
      out_size    = w_head[17:2];
      out_is_face = w_head[1];
      out_last    = w_head[0];
    end
  end

endmodule

// File: tb/tb_face_result_buffer.sv
// Directed bench for face_result_buffer: rescale table plus frame, drop,
// backpressure and reset sequences.
module tb_face_result_buffer;

  logic             clock = 1'b0;
  logic             reset;
  logic [1:0][31:0] face_coords;
  logic             face_coords_ready;
  logic [3:0]       pyramid_number;
  logic             vj_pipeline_done;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_row, out_col, out_size;
  logic             out_is_face, out_last;
  logic [7:0]       face_count, drop_count;

  int checks = 0;
  int errors = 0;

  face_result_buffer #(.FIFO_DEPTH(16), .WINDOW_SIZE(24), .NUM_LEVELS(10)) dut (
    .clock(clock), .reset(reset), .face_coords(face_coords),
    .face_coords_ready(face_coords_ready), .pyramid_number(pyramid_number),
    .vj_pipeline_done(vj_pipeline_done), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_col(out_col), .out_size(out_size),
    .out_is_face(out_is_face), .out_last(out_last),
    .face_count(face_count), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] row_w;
    logic [31:0] col_w;
    logic [3:0]  lvl;
    logic [15:0] e_row;
    logic [15:0] e_col;
    logic [15:0] e_size;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic send(input logic [31:0] r, input logic [31:0] c, input logic [3:0] l,
                      input logic f, input logic d);
    face_coords[0]    = r;
    face_coords[1]    = c;
    pyramid_number    = l;
    face_coords_ready = f;
    vj_pipeline_done  = d;
    tick();
    face_coords_ready = 1'b0;
    vj_pipeline_done  = 1'b0;
  endtask

  task automatic check_entry(input string nm, input logic [15:0] r, input logic [15:0] c,
                             input logic [15:0] s, input logic f, input logic l);
    chk({nm, ".valid"}, 32'(out_valid), 32'd1);
    chk({nm, ".row"}, 32'(out_row), 32'(r));
    chk({nm, ".col"}, 32'(out_col), 32'(c));
    chk({nm, ".size"}, 32'(out_size), 32'(s));
    chk({nm, ".is_face"}, 32'(out_is_face), 32'(f));
    chk({nm, ".last"}, 32'(out_last), 32'(l));
  endtask

  initial begin
    vecs[0] = '{32'd10, 32'd20, 4'd0, 16'd10, 16'd20, 16'd24};
    vecs[1] = '{32'd10, 32'd7, 4'd3, 16'd19, 16'd13, 16'd46};
    vecs[2] = '{32'd100, 32'd0, 4'd9, 16'd744, 16'd0, 16'd178};
    vecs[3] = '{32'hABCD_03E8, 32'hFFFF_0003, 4'd1, 16'd1250, 16'd3, 16'd30};
    vecs[4] = '{32'd65535, 32'd256, 4'd5, 16'hFFFF, 16'd781, 16'd73};
    vecs[5] = '{32'd256, 32'd255, 4'd2, 16'd400, 16'd398, 16'd37};
    vecs[6] = '{32'd512, 32'd100, 4'd4, 16'd1250, 16'd244, 16'd58};
    vecs[7] = '{32'd33, 32'h1234_03E8, 4'd6, 16'd125, 16'd3816, 16'd91};
    vecs[8] = '{32'd5, 32'd6, 4'd7, 16'd23, 16'd28, 16'd114};
    vecs[9] = '{32'd40, 32'd2, 4'd8, 16'd238, 16'd11, 16'd143};

    reset = 1'b0;
    face_coords = '0;
    face_coords_ready = 1'b0;
    pyramid_number = '0;
    vj_pipeline_done = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.row", 32'(out_row), 32'd0);
    chk("rst.last", 32'(out_last), 32'd0);
    chk("rst.face_count", 32'(face_count), 32'd0);
    chk("rst.drop_count", 32'(drop_count), 32'd0);
    reset = 1'b1;
    tick();

    // Rescale table: one face at a time into an empty FIFO.
    for (int i = 0; i < 10; i++) begin
      send(vecs[i].row_w, vecs[i].col_w, vecs[i].lvl, 1'b1, 1'b0);
      tick();
      chk($sformatf("vec%0d.early", i), 32'(out_valid), 32'd0);
      tick();
      check_entry($sformatf("vec%0d", i), vecs[i].e_row, vecs[i].e_col, vecs[i].e_size,
                  1'b1, 1'b0);
      tick();
    end
    chk("tbl.face_count", 32'(face_count), 32'd10);
    chk("tbl.drop_count", 32'(drop_count), 32'd0);

    // Terminator pops and clears the frame counters.
    send(32'd0, 32'd0, 4'd0, 1'b0, 1'b1);
    tick();
    tick();
    check_entry("term", 16'd0, 16'd0, 16'd0, 1'b0, 1'b1);
    chk("term.face_count_pre", 32'(face_count), 32'd10);
    tick();
    chk("term.face_count_post", 32'(face_count), 32'd0);
    chk("term.valid_post", 32'(out_valid), 32'd0);

    // Face and done together on an empty FIFO.
    send(32'd3, 32'd4, 4'd0, 1'b1, 1'b1);
    tick();
    tick();
    check_entry("combo", 16'd3, 16'd4, 16'd24, 1'b1, 1'b1);
    chk("combo.face_count", 32'(face_count), 32'd1);
    tick();
    chk("combo.face_count_post", 32'(face_count), 32'd0);

    // Out-of-range pyramid level.
    send(32'd5, 32'd5, 4'd12, 1'b1, 1'b0);
    tick();
    tick();
    chk("badlvl.valid", 32'(out_valid), 32'd0);
    chk("badlvl.drop_count", 32'(drop_count), 32'd1);
    chk("badlvl.face_count", 32'(face_count), 32'd0);
    send(32'd0, 32'd0, 4'd0, 1'b0, 1'b1);
    tick();
    tick();
    check_entry("badlvl.term", 16'd0, 16'd0, 16'd0, 1'b0, 1'b1);
    tick();
    chk("badlvl.drop_post", 32'(drop_count), 32'd0);

    // Backpressure: 20 faces then face+done with one slot left.
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      face_coords[0] = 32'(i);
      face_coords[1] = 32'(i + 100);
      pyramid_number = 4'd0;
      face_coords_ready = 1'b1;
      tick();
    end
    face_coords[0] = 32'd99;
    face_coords[1] = 32'd99;
    vj_pipeline_done = 1'b1;
    tick();
    face_coords_ready = 1'b0;
    vj_pipeline_done = 1'b0;
    repeat (3) tick();
    chk("bp.face_count", 32'(face_count), 32'd15);
    chk("bp.drop_count", 32'(drop_count), 32'd6);
    chk("bp.head_row", 32'(out_row), 32'd0);
    tick();
    chk("bp.hold_row", 32'(out_row), 32'd0);
    chk("bp.hold_col", 32'(out_col), 32'd100);
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k < 15)
        check_entry($sformatf("bp%0d", k), 16'(k), 16'(k + 100), 16'd24, 1'b1, 1'b0);
      else
        check_entry("bp.term", 16'd0, 16'd0, 16'd0, 1'b0, 1'b1);
      tick();
    end
    chk("bp.empty", 32'(out_valid), 32'd0);
    chk("bp.face_post", 32'(face_count), 32'd0);
    chk("bp.drop_post", 32'(drop_count), 32'd0);

    // Reset with entries queued mid-frame.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      face_coords[0] = 32'(i + 1);
      face_coords[1] = 32'(i + 2);
      pyramid_number = 4'd0;
      face_coords_ready = 1'b1;
      tick();
    end
    face_coords_ready = 1'b0;
    repeat (3) tick();
    chk("mid.face_count", 32'(face_count), 32'd5);
    reset = 1'b0;
    tick();
    chk("mid.rst_valid", 32'(out_valid), 32'd0);
    chk("mid.rst_row", 32'(out_row), 32'd0);
    chk("mid.rst_face", 32'(face_count), 32'd0);
    chk("mid.rst_drop", 32'(drop_count), 32'd0);
    reset = 1'b1;
    out_ready = 1'b1;
    send(32'd7, 32'd8, 4'd0, 1'b1, 1'b0);
    tick();
    chk("fresh.early", 32'(out_valid), 32'd0);
    tick();
    check_entry("fresh", 16'd7, 16'd8, 16'd24, 1'b1, 1'b0);
    chk("fresh.face_count", 32'(face_count), 32'd1);
    tick();
    chk("fresh.empty", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
